// File: rtl/divmod_hs.sv
// divmod_hs: iterative restoring integer divider with valid/ready handshakes.
// The per-operation sgn input selects signed or unsigned division.
// Divide-by-zero and MIN / -1 take a one-cycle fast path with defined results.
// Every other operation takes a fixed WIDTH+2 cycles.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for operands; outputs hold the previous result
// CALC  | one restoring step per cycle, counter runs WIDTH down to 1
// FIX   | apply result signs and write div/mod
// DONE  | result presented, held until out_ready
module divmod_hs #(
  parameter  int WIDTH_LOG = 4,
  localparam int WIDTH     = 1 << WIDTH_LOG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] mod,
  output logic             error,
  output logic             ovf
);

  localparam int CW = WIDTH_LOG + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;      // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dsr;      // divisor magnitude
  logic [WIDTH-1:0] rem;      // partial remainder
  logic             neg_q, neg_r;

  logic             accept, fast_zero, fast_ovf, last_step, take;
  logic [WIDTH-1:0] min_val, a_mag, b_mag;
  logic [WIDTH:0]   shifted;

  assign min_val   = {1'b1, {(WIDTH-1){1'b0}}};
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign fast_zero = (b == '0);
  assign fast_ovf  = sgn && (a == min_val) && (b == '1);
  assign a_mag     = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (sgn && b[WIDTH-1]) ? -b : b;
  // The remainder stays below dsr, so the shifted value needs one extra bit.
  // When take is set, the difference fits back into WIDTH bits.
  assign shifted   = {rem, dvd[WIDTH-1]};
  assign take      = (shifted >= {1'b0, dsr});
  assign last_step = (cnt == CW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (fast_zero || fast_ovf) ? DONE : CALC;
      CALC: if (last_step) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, restoring iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      dvd   <= '0;
      dsr   <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div   <= '0;
      mod   <= '0;
      error <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (fast_zero) begin
              div   <= '1;
              mod   <= a;
              error <= 1'b1;
              ovf   <= 1'b0;
            end else if (fast_ovf) begin
              div   <= min_val;
              mod   <= '0;
              error <= 1'b0;
              ovf   <= 1'b1;
            end else begin
              dvd   <= a_mag;
              dsr   <= b_mag;
              rem   <= '0;
              cnt   <= CW'(WIDTH);
              neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r <= sgn && a[WIDTH-1];
            end
          end
        end
        CALC: begin
          rem <= take ? (shifted[WIDTH-1:0] - dsr) : shifted[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], take};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          div   <= neg_q ? -dvd : dvd;
          mod   <= neg_r ? -rem : rem;
          error <= 1'b0;
          ovf   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divmod_hs.sv
// tb_divmod_hs: directed vector table and corner sequences at WIDTH_LOG=4.
// Also runs a random sweep at WIDTH_LOG=2..6 against a native-arithmetic model.
module tb_divmod_hs;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, sgn, out_valid, out_ready, error, ovf;
  logic [15:0] a_in, b_in, div, mod;

  int n_chk = 0;
  int n_err = 0;

  divmod_hs #(.WIDTH_LOG(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_in), .b(b_in), .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready),
    .div(div), .mod(mod), .error(error), .ovf(ovf)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one operation. Return the cycle count from accept to out_valid.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                       output int lat);
    @(negedge clk);
    a_in = ta; b_in = tb; sgn = ts; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        s;
    logic [15:0] q, r;
    logic        e, o;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat, guard;
    logic all_done;

    vecs[0]  = '{16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0, 1'b0, 18};
    vecs[1]  = '{16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 18};
    vecs[2]  = '{16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 18};
    vecs[3]  = '{16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1};
    vecs[4]  = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1, 1};
    vecs[5]  = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 18};
    vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 18};
    vecs[7]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0, 18};
    vecs[8]  = '{16'hFF9C, 16'hFFF9, 1'b1, 16'd14,   16'hFFFE, 1'b0, 1'b0, 18};
    vecs[9]  = '{16'h0000, 16'h0005, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 18};
    vecs[10] = '{16'h8000, 16'h0000, 1'b1, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1};
    vecs[11] = '{16'd5,    16'd9,    1'b0, 16'd0,    16'd5,    1'b0, 1'b0, 18};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0; sgn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_div", div, 0);
    chk("rst_mod", mod, 0);
    chk("rst_error", error, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, lat);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_div", i), div, vecs[i].q);
      chk($sformatf("v%0d_mod", i), mod, vecs[i].r);
      chk($sformatf("v%0d_error", i), error, vecs[i].e);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].o);
      chk($sformatf("v%0d_in_ready_busy", i), in_ready, 0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_handoff", i), out_valid, 0);
    end

    // Back-pressure: result held while out_ready is low.
    // New operands offered during DONE and at the handoff edge must be ignored.
    out_ready = 1'b0;
    do_op(16'd100, 16'd7, 1'b0, lat);
    chk("bp_lat", lat, 18);
    a_in = 16'h0055; b_in = 16'h0000; sgn = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_out_valid", k), out_valid, 1);
      chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
      chk($sformatf("bp%0d_div", k), div, 14);
      chk($sformatf("bp%0d_mod", k), mod, 2);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_idle_div_held", div, 14);
    chk("bp_idle_mod_held", mod, 2);
    chk("bp_idle_error_held", error, 0);

    // Reset in cycle N+5 of a normal operation.
    @(negedge clk);
    a_in = 16'd100; b_in = 16'd7; sgn = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_div", div, 0);
    chk("midrst_mod", mod, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_still_idle", out_valid, 0);

    do_op(16'd1000, 16'd33, 1'b0, lat);
    chk("post_rst_lat", lat, 18);
    chk("post_rst_div", div, 30);
    chk("post_rst_mod", mod, 10);
    @(posedge clk);
    #1;

    guard = 0;
    all_done = 1'b0;
    while (!all_done && guard < 20000) begin
      @(posedge clk);
      guard++;
      all_done = g_sw[2].done && g_sw[3].done && g_sw[4].done &&
                 g_sw[5].done && g_sw[6].done;
    end
    chk("sweep_complete", all_done, 1);

    n_chk += g_sw[2].s_chk + g_sw[3].s_chk + g_sw[4].s_chk + g_sw[5].s_chk + g_sw[6].s_chk;
    n_err += g_sw[2].s_err + g_sw[3].s_err + g_sw[4].s_err + g_sw[5].s_err + g_sw[6].s_err;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // Random sweep: one independent instance per width.
  for (genvar gl = 2; gl <= 6; gl++) begin : g_sw
    localparam int W = 1 << gl;

    logic         s_rst, s_iv, s_ir, s_sg, s_ov, s_or, s_er, s_of;
    logic [W-1:0] s_a, s_b, s_q, s_r;
    int           s_chk = 0;
    int           s_err = 0;
    logic         done = 1'b0;

    divmod_hs #(.WIDTH_LOG(gl)) u_dut (
      .clk(clk), .rst(s_rst), .in_valid(s_iv), .in_ready(s_ir),
      .a(s_a), .b(s_b), .sgn(s_sg), .out_valid(s_ov), .out_ready(s_or),
      .div(s_q), .mod(s_r), .error(s_er), .ovf(s_of)
    );

    task automatic schk(string nm, logic [63:0] act, logic [63:0] exp);
      s_chk++;
      if (act !== exp) begin
        s_err++;
        $display("FAIL w%0d %s: got %0h expected %0h", W, nm, act, exp);
      end
    endtask

    initial begin
      logic [W-1:0]    min_v, eq, er;
      logic            ee, eo;
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub, uq, ur;
      logic [63:0]     r1, r2;
      int              lat, elat;

      min_v = '0;
      min_v[W-1] = 1'b1;
      s_rst = 1'b1; s_iv = 1'b0; s_or = 1'b1; s_a = '0; s_b = '0; s_sg = 1'b0;
      repeat (2) @(posedge clk);
      #1 s_rst = 1'b0;

      for (int i = 0; i < 30; i++) begin
        r1 = {$urandom(), $urandom()};
        r2 = {$urandom(), $urandom()};
        @(negedge clk);
        s_a  = r1[W-1:0];
        s_b  = r2[W-1:0] >> $urandom_range(W-1, 0);
        s_sg = 1'($urandom_range(1, 0));
        if (i % 10 == 3) s_b = '0;
        if (i % 10 == 7) begin
          s_a = min_v; s_b = '1; s_sg = 1'b1;
        end

        sa = $signed(s_a);
        sb = $signed(s_b);
        ua = s_a;
        ub = s_b;
        ee = 1'b0; eo = 1'b0;
        if (s_b == '0) begin
          eq = '1; er = s_a; ee = 1'b1; elat = 1;
        end else if (s_sg && s_a == min_v && s_b == '1) begin
          eq = min_v; er = '0; eo = 1'b1; elat = 1;
        end else begin
          elat = W + 2;
          if (s_sg) begin
            sq = sa / sb; sr = sa % sb;
            eq = sq[W-1:0]; er = sr[W-1:0];
          end else begin
            uq = ua / ub; ur = ua % ub;
            eq = uq[W-1:0]; er = ur[W-1:0];
          end
        end

        s_iv = 1'b1;
        @(posedge clk);
        #1 s_iv = 1'b0;
        lat = 1;
        while (!s_ov && lat < 200) begin
          @(posedge clk);
          #1 lat++;
        end
        schk($sformatf("op%0d_lat", i), lat, elat);
        schk($sformatf("op%0d_div", i), s_q, eq);
        schk($sformatf("op%0d_mod", i), s_r, er);
        schk($sformatf("op%0d_error", i), s_er, ee);
        schk($sformatf("op%0d_ovf", i), s_of, eo);
        @(posedge clk);
        #1;
        schk($sformatf("op%0d_handoff", i), s_ir, 1);
      end
      done = 1'b1;
    end
  end

endmodule

// File: doc/divmod_hs.md
Name: divmod_hs

Overview:
- Parametrised iterative integer divider, successor to the plain divmod block.
- Adds per-operation signed/unsigned mode, valid/ready handshakes on both input and output, and fixed deterministic latency.
- Gives defined (non-X) results for divide-by-zero and signed overflow.
- Sits between operand producers (e.g. prime-search control) and consumers that may stall.

Parameters:
- WIDTH_LOG, default 4: operand width is WIDTH = 1 << WIDTH_LOG; legal range 2..6.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, sgn are presented.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  dividend.
- b  input  WIDTH  divisor.
- sgn  input  1  1 = two's-complement signed operation; 0 = unsigned.
- out_valid  output  1  div, mod, error, ovf hold a result.
- out_ready  input  1  consumer takes the result.
- div  output  WIDTH  quotient.
- mod  output  WIDTH  remainder.
- error  output  1  divide-by-zero occurred.
- ovf  output  1  signed overflow occurred (MIN / -1).

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, div=0, mod=0, error=0, ovf=0. Internal registers cleared; no X on any output.
- rst mid-operation (CALC, FIX or DONE): aborts unconditionally; the pending result is discarded and the same reset values are applied.
- States: IDLE, CALC, FIX, DONE. in_ready = (state==IDLE), combinational from state only.
- Accept: in_valid && in_ready at a rising edge latches a, b, sgn. Inputs are ignored in every other cycle.
- Fast path, b==0: go directly to DONE.
  - Outputs: error=1, ovf=0, div=all ones, mod=a.
- Fast path, sgn=1 && a==MIN && b==all ones: go directly to DONE.
  - Outputs: ovf=1, error=0, div=MIN, mod=0.
- Normal path: on accept, load magnitudes |a|, |b| (negated only when sgn=1 and the MSB is set), record result signs, clear the partial remainder and set the iteration counter (WIDTH_LOG+1 bits) to WIDTH; go to CALC.
- CALC: one restoring step per cycle:
  - shift the partial remainder left, bringing in the next dividend bit MSB-first;
  - if remainder >= |b|, subtract and set the quotient bit, else set it to 0;
  - decrement the counter; after exactly WIDTH steps go to FIX.
- FIX: one cycle; applies signs and drives div/mod, error=0, ovf=0, then goes to DONE.
  - Quotient is negated if sgn && (a[MSB] xor b[MSB]).
  - Remainder is negated if sgn && a[MSB].
- Result semantics:
  - Unsigned: div=floor(a/b), mod=a-div*b.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend, |mod| < |b|, a = div*b + mod.
- Latency, with N the accept cycle:
  - out_valid first high in cycle N+1 on either fast path;
  - out_valid first high in cycle N+WIDTH+2 on the normal path.
  - Latency is independent of operand values.
- DONE: out_valid=1; div, mod, error and ovf are held stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE, out_valid=0 next cycle.
  - Outputs keep their last values in IDLE until the next result is written.
- No accept in the same cycle as the result handoff; in_ready rises the cycle after the handoff.
- Throughput: at most one operation per WIDTH+3 cycles on the normal path.

Test Plan:
- WIDTH_LOG=4, unsigned a=100, b=7 -> div=14, mod=2; out_valid in cycle N+18.
- Signed a=0xFFF9 (-7), b=0x0002 -> div=0xFFFD (-3), mod=0xFFFF (-1).
- Signed a=7, b=0xFFFE -> div=0xFFFD, mod=1.
- b=0, a=0x1234, sgn=0 -> error=1, div=0xFFFF, mod=0x1234; out_valid in cycle N+1.
- Signed a=0x8000, b=0xFFFF -> ovf=1, div=0x8000, mod=0; latency 1.
- Unsigned a=0xFFFF, b=1 -> div=0xFFFF, mod=0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; release -> out_valid low next cycle, in_ready high.
- Reset: assert rst in cycle N+5 of a normal operation -> next cycle IDLE, in_ready=1, out_valid=0, div=mod=0.
- Reset follow-up: a new operation after the reset completes correctly.
- Sweep WIDTH_LOG=2..6 with random operands -> results match a reference model; latency = WIDTH+2 on every normal-path operation.
